// File: rtl/param_modulo_counter.sv
// Modulo counter with a run-time limit register and wrap, saturate and one-shot modes.
// Every output comes straight from a flop. rst_n is asynchronous and resets while high.
module param_modulo_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             lim_wr,
  input  logic [WIDTH-1:0] lim_val,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mode_t            mode_e;
  logic             is_sat, is_oneshot, is_wrap;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] stepped;
  logic             step;
  logic             sat_hold;
  logic             reach;

  always_comb begin
    mode_e     = mode_t'(mode);
    is_sat     = (mode_e == MODE_SAT);
    is_oneshot = (mode_e == MODE_ONESHOT);
    is_wrap    = !is_sat && !is_oneshot;
    term       = up ? limit_q : '0;
    // The clamp deliberately uses the limit as it stands before any same-cycle limit write.
    load_clamped = (load_val > limit_q) ? limit_q : load_val;
    step       = en && !load && (!is_oneshot || state_q == ST_RUN);
  end

  // One-shot runs use saturate arithmetic, so only wrap mode folds around the ends.
  always_comb begin
    stepped = count_q;
    if (up) begin
      if (count_q >= limit_q) stepped = is_wrap ? '0 : limit_q;
      else                    stepped = count_q + 1'b1;
    end else begin
      if (count_q == '0)      stepped = is_wrap ? limit_q : '0;
      else                    stepped = count_q - 1'b1;
    end
  end

  // A saturated counter that cannot move is holding, not stepping, so it must not
  // re-pulse tc. Wrap with limit 0 does pulse every enabled cycle.
  always_comb begin
    sat_hold = is_sat && (stepped == count_q);
    reach    = step && (stepped == term) && !sat_hold;
  end

  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    tc_d    = 1'b0;
    if (load)      count_d = load_clamped;
    else if (step) count_d = stepped;
    if (lim_wr)    limit_d = lim_val;
    if (!load)     tc_d = reach;
  end

  // NOTE: every signal assigned in an always_comb gets a default first so that no path
  // leaves it unassigned; a missing default is how latches get inferred.
  always_comb begin
    state_d = state_q;
    if (!is_oneshot) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && reach) begin
      state_d = ST_DONE;
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values no matter how the always_ff blocks are ordered.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= RESET_LIMIT;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign limit = limit_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_param_modulo_counter.sv
// Scoreboard bench for param_modulo_counter: each stimulus row pushes its expected
// outputs, and the entry is popped and compared once the clock edge has produced them.
module tb_param_modulo_counter;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             lim_wr;
    logic [WIDTH-1:0] lim_val;
    logic             up;
    logic [1:0]       mode;
  } stim_t;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] limit;
    logic             tc;
    logic             busy;
    logic             done;
  } outs_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0, load = 1'b0, lim_wr = 1'b0, up = 1'b1;
  logic [WIDTH-1:0] load_val = '0, lim_val = '0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] count, limit;
  logic             tc, busy, done;

  int    n_checks = 0;
  int    n_fail   = 0;
  outs_t sb[$];

  param_modulo_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .lim_wr(lim_wr), .lim_val(lim_val), .up(up), .mode(mode),
    .count(count), .limit(limit), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic stim_t s(input logic e, input logic ld, input int lv,
                              input logic lw, input int lmv, input logic u, input logic [1:0] m);
    s = '{en: e, load: ld, load_val: lv[WIDTH-1:0], lim_wr: lw, lim_val: lmv[WIDTH-1:0], up: u, mode: m};
  endfunction

  function automatic outs_t o(input int c, input int l, input logic t, input logic b, input logic d);
    o = '{count: c[WIDTH-1:0], limit: l[WIDTH-1:0], tc: t, busy: b, done: d};
  endfunction

  function automatic string fmt(input outs_t v);
    fmt = $sformatf("count=%0d limit=%0d tc=%b busy=%b done=%b", v.count, v.limit, v.tc, v.busy, v.done);
  endfunction

  function automatic outs_t sample();
    sample = '{count: count, limit: limit, tc: tc, busy: busy, done: done};
  endfunction

  task automatic apply(input stim_t v);
    en = v.en; load = v.load; load_val = v.load_val;
    lim_wr = v.lim_wr; lim_val = v.lim_val; up = v.up; mode = v.mode;
  endtask

  task automatic test_reset();
    outs_t exp_o, obs;
    apply(s(0, 0, 0, 0, 0, 1, 2'b00));
    sb.push_back(o(0, 255, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    exp_o = sb.pop_front();
    obs = sample();
    n_checks++;
    if (obs !== exp_o) begin
      n_fail++;
      $display("FAIL reset: got %s, want %s", fmt(obs), fmt(exp_o));
    end
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_wrap();
    stim_t st[$];
    outs_t ex[$];
    outs_t exp_o, obs;
    st.push_back(s(0, 0, 0, 1, 5, 1, 2'b00)); ex.push_back(o(0, 5, 0, 0, 0));
    for (int i = 0; i < 7; i++) begin
      int c;
      c = (i + 1) % 6;
      st.push_back(s(1, 0, 0, 0, 0, 1, 2'b00));
      ex.push_back(o(c, 5, c == 5, 0, 0));
    end
    st.push_back(s(0, 1, 0, 0, 0, 0, 2'b00)); ex.push_back(o(0, 5, 0, 0, 0));
    for (int i = 0; i < 7; i++) begin
      int c;
      c = (i == 0 || i == 6) ? 5 : 5 - i;
      st.push_back(s(1, 0, 0, 0, 0, 0, (i == 3) ? 2'b11 : 2'b00));
      ex.push_back(o(c, 5, i == 5, 0, 0));
    end
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(obs), fmt(exp_o));
      end
    end
  endtask

  task automatic test_saturate();
    stim_t st[$];
    outs_t ex[$];
    outs_t exp_o, obs;
    st.push_back(s(0, 0, 0, 1, 255, 1, 2'b01)); ex.push_back(o(5, 255, 0, 0, 0));
    st.push_back(s(1, 1, 250, 0, 0, 1, 2'b01)); ex.push_back(o(250, 255, 0, 0, 0));
    for (int i = 1; i <= 7; i++) begin
      int c;
      c = (250 + i > 255) ? 255 : 250 + i;
      st.push_back(s(1, 0, 0, 0, 0, 1, 2'b01));
      ex.push_back(o(c, 255, i == 5, 0, 0));
    end
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %s, want %s", i, fmt(obs), fmt(exp_o));
      end
    end
  endtask

  task automatic test_oneshot();
    stim_t st[$];
    outs_t ex[$];
    outs_t exp_o, obs;
    st.push_back(s(1, 0, 0, 1, 3, 1, 2'b10)); ex.push_back(o(255, 3, 0, 0, 0));
    st.push_back(s(0, 1, 0, 0, 0, 1, 2'b10)); ex.push_back(o(0, 3, 0, 1, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b10)); ex.push_back(o(1, 3, 0, 1, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b10)); ex.push_back(o(2, 3, 0, 1, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b10)); ex.push_back(o(3, 3, 1, 0, 1));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b10)); ex.push_back(o(3, 3, 0, 0, 1));
    st.push_back(s(1, 0, 0, 0, 0, 0, 2'b10)); ex.push_back(o(3, 3, 0, 0, 1));
    st.push_back(s(0, 0, 0, 0, 0, 1, 2'b00)); ex.push_back(o(3, 3, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL oneshot[%0d]: got %s, want %s", i, fmt(obs), fmt(exp_o));
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[$];
    outs_t ex[$];
    outs_t exp_o, obs;
    st.push_back(s(0, 0, 0, 1, 255, 1, 2'b00)); ex.push_back(o(3, 255, 0, 0, 0));
    st.push_back(s(1, 1, 7, 0, 0, 1, 2'b00));   ex.push_back(o(7, 255, 0, 0, 0));
    st.push_back(s(0, 0, 0, 1, 100, 1, 2'b00)); ex.push_back(o(7, 100, 0, 0, 0));
    st.push_back(s(0, 1, 200, 0, 0, 1, 2'b00)); ex.push_back(o(100, 100, 0, 0, 0));
    st.push_back(s(0, 1, 50, 1, 20, 1, 2'b00)); ex.push_back(o(50, 20, 0, 0, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b00));   ex.push_back(o(0, 20, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL priority[%0d]: got %s, want %s", i, fmt(obs), fmt(exp_o));
      end
    end
  endtask

  task automatic test_shrink();
    stim_t st[$];
    outs_t ex[$];
    outs_t exp_o, obs;
    st.push_back(s(0, 1, 9, 0, 0, 1, 2'b00)); ex.push_back(o(9, 20, 0, 0, 0));
    st.push_back(s(0, 0, 0, 1, 4, 1, 2'b00)); ex.push_back(o(9, 4, 0, 0, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b00)); ex.push_back(o(0, 4, 0, 0, 0));
    st.push_back(s(0, 0, 0, 1, 20, 1, 2'b01)); ex.push_back(o(0, 20, 0, 0, 0));
    st.push_back(s(0, 1, 9, 0, 0, 1, 2'b01)); ex.push_back(o(9, 20, 0, 0, 0));
    st.push_back(s(0, 0, 0, 1, 4, 1, 2'b01)); ex.push_back(o(9, 4, 0, 0, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b01)); ex.push_back(o(4, 4, 1, 0, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b01)); ex.push_back(o(4, 4, 0, 0, 0));
    st.push_back(s(0, 0, 0, 1, 0, 1, 2'b00)); ex.push_back(o(4, 0, 0, 0, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b00)); ex.push_back(o(0, 0, 1, 0, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b00)); ex.push_back(o(0, 0, 1, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL shrink[%0d]: got %s, want %s", i, fmt(obs), fmt(exp_o));
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t st[$];
    outs_t ex[$];
    outs_t exp_o, obs;
    st.push_back(s(0, 0, 0, 1, 200, 1, 2'b10)); ex.push_back(o(0, 200, 0, 0, 0));
    st.push_back(s(0, 1, 0, 0, 0, 1, 2'b10));   ex.push_back(o(0, 200, 0, 1, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b10));   ex.push_back(o(1, 200, 0, 1, 0));
    st.push_back(s(1, 0, 0, 0, 0, 1, 2'b10));   ex.push_back(o(2, 200, 0, 1, 0));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL async_setup[%0d]: got %s, want %s", i, fmt(obs), fmt(exp_o));
      end
    end
    // Reset is raised and dropped entirely between two rising edges.
    #2 rst_n = 1'b1;
    sb.push_back(o(0, 255, 0, 0, 0));
    #1;
    exp_o = sb.pop_front();
    obs = sample();
    n_checks++;
    if (obs !== exp_o) begin
      n_fail++;
      $display("FAIL async_reset: got %s, want %s", fmt(obs), fmt(exp_o));
    end
    rst_n = 1'b0;
    sb.push_back(o(0, 255, 0, 0, 0));
    @(posedge clk);
    #1;
    exp_o = sb.pop_front();
    obs = sample();
    n_checks++;
    if (obs !== exp_o) begin
      n_fail++;
      $display("FAIL after_reset: got %s, want %s", fmt(obs), fmt(exp_o));
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_priority();
    test_shrink();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_modulo_counter.md
PARAM_MODULO_COUNTER -- requirements
Module: param_modulo_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter, load and limit width (2..32).
REQ-002 SHALL have parameter RESET_LIMIT, default {WIDTH{1'b1}}: limit register value after reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high (rst_n=1 resets).
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port load  input  1  synchronous load of load_val into count.
REQ-007 SHALL have port load_val  input  WIDTH  load data.
REQ-008 SHALL have port lim_wr  input  1  write strobe for limit register.
REQ-009 SHALL have port lim_val  input  WIDTH  new limit value.
REQ-010 SHALL have port up  input  1  direction: 1=up, 0=down.
REQ-011 SHALL have port mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port limit  output  WIDTH  registered limit value.
REQ-014 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 SHALL have port busy  output  1  one-shot FSM in RUN.
REQ-016 SHALL have port done  output  1  one-shot FSM in DONE (sticky).

Function
REQ-017 SHALL define terminal value T = limit when up=1, T = 0 when up=0, using the current-cycle limit and up.
REQ-018 SHALL load limit <= lim_val on a clk edge with lim_wr=1; new limit used from the following cycle.
REQ-019 SHALL give priority load > counting; load and en together: load wins, no step, no tc.
REQ-020 SHALL on load set count <= min(load_val, limit) using the limit before any same-cycle lim_wr.
REQ-021 SHALL step count by exactly 1 per enabled cycle (en=1, load=0, counting allowed per REQ-026..028).
REQ-022 SHALL in wrap mode: up at count>=limit -> 0; down at count=0 -> limit; else +/-1 modulo limit+1.
REQ-023 SHALL in saturate mode: up at count>=limit -> limit; down at 0 -> hold 0; else +/-1.
REQ-024 SHALL assert tc for exactly the cycle after a counting step leaves count equal to T; never from load or hold.
REQ-025 SHALL not re-pulse tc while saturated at T (step to same value with count already T is a hold, not a step).
REQ-026 SHALL run one-shot FSM with states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-027 SHALL transition IDLE/RUN/DONE -> RUN on load while mode=10; RUN -> DONE on the step that reaches T (tc pulses same cycle as done rises).
REQ-028 SHALL in one-shot mode count only in RUN, with saturate arithmetic; en ignored in IDLE and DONE; count holds in DONE.
REQ-029 SHALL force FSM to IDLE on any cycle with mode != 10; wrap/saturate counting proceeds regardless of FSM.
REQ-030 SHALL allow direction change mid-count with effect on the same edge; one-shot in RUN then terminates at new T.
REQ-031 SHALL with limit lowered below count, up step goes to 0 (wrap) or limit (saturate/one-shot); limit=0 up/wrap holds 0 and pulses tc each enabled cycle.
REQ-032 SHALL keep all outputs glitch-free, driven directly from flops.

Reset
REQ-033 SHALL on rst_n=1, immediately and independent of clk: count=0, limit=RESET_LIMIT, tc=0, busy=0, done=0, FSM=IDLE.
REQ-034 SHALL abort a one-shot in RUN on mid-operation reset; first edge after rst_n falls to 0 behaves as from fresh reset.

Verification
REQ-035 SHALL test wrap up: WIDTH=8, lim 5, mode 00, up=1, en=1 from 0 -> count 1,2,3,4,5,0,1; tc high only the cycle count=5.
REQ-036 SHALL test wrap down/saturate: mode 00, up=0, count 0, lim 5 -> 5; mode 01, up=1, load 250, lim 255 -> ..255,255; tc once.
REQ-037 SHALL test one-shot: mode 10, lim 3, load 0 -> busy=1; en x3 -> count 3, done=1, busy=0, tc once; further en -> count stays 3.
REQ-038 SHALL test priority: load 7 with en=1 -> count 7, tc=0; load 200 with lim 100 -> count 100; load 50 with lim_wr 20 same cycle -> count 50, limit 20.
REQ-039 SHALL test limit shrink: count 9, lim_wr 4, mode 00 up en -> count 0; mode 01 -> count 4.
REQ-040 SHALL test async reset: assert rst_n=1 between edges mid-RUN -> count 0, busy 0, done 0, limit RESET_LIMIT before next edge.
